tempo_record_ctrl: RTL and testbench

//  Parametrised record/playback sequencer for the music-box datapath. Contains a

---
 rtl/tempo_pkg.sv | 38 +++
 rtl/tempo_record_ctrl_beat_gen.sv | 60 ++++++
 rtl/tempo_record_ctrl.sv | 146 ++++++++++++++
 tb/tb_tempo_record_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tempo_pkg.sv
// Shared types and constants for the tempo record/playback controller.
// Beat periods come from a constant BPM table so no divider is synthesised.
package tempo_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_REC   = 3'd2,
    S_STOP  = 3'd3,
    S_PLAY  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_REC  = 2'd1;
  localparam logic [1:0] MODE_PLAY = 2'd2;

  function automatic int unsigned bpm(input logic [2:0] idx);
    unique case (idx)
      3'd0: return 40;
      3'd1: return 60;
      3'd2: return 80;
      3'd3: return 100;
      3'd4: return 120;
      3'd5: return 140;
      3'd6: return 180;
      default: return 220;
    endcase
  endfunction

  function automatic int unsigned period(
    input int unsigned clk_hz,
    input logic [2:0]  idx
  );
    longint unsigned p;
    p = (longint'(clk_hz) * 60) / longint'(bpm(idx));
    return int'(p);
  endfunction

endpackage

// File: rtl/tempo_record_ctrl_beat_gen.sv
// Down-counting beat generator with per-speed period table and
// a guard window after each reload during which notes are not sampled.
module tempo_record_ctrl_beat_gen
  import tempo_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned CNT_W  = 27,
  parameter int unsigned GUARD  = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] speed_i,
  input  logic       reload_i,
  output logic       beat_tick_o,
  output logic       note_window_o
);

  localparam logic [CNT_W-1:0] P0 = CNT_W'(period(CLK_HZ, 3'd0));
  localparam logic [CNT_W-1:0] P1 = CNT_W'(period(CLK_HZ, 3'd1));
  localparam logic [CNT_W-1:0] P2 = CNT_W'(period(CLK_HZ, 3'd2));
  localparam logic [CNT_W-1:0] P3 = CNT_W'(period(CLK_HZ, 3'd3));
  localparam logic [CNT_W-1:0] P4 = CNT_W'(period(CLK_HZ, 3'd4));
  localparam logic [CNT_W-1:0] P5 = CNT_W'(period(CLK_HZ, 3'd5));
  localparam logic [CNT_W-1:0] P6 = CNT_W'(period(CLK_HZ, 3'd6));
  localparam logic [CNT_W-1:0] P7 = CNT_W'(period(CLK_HZ, 3'd7));
  localparam logic [CNT_W-1:0] GRD = CNT_W'(GUARD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    per = P7;
    unique case (speed_i)
      3'd0: per = P0;
      3'd1: per = P1;
      3'd2: per = P2;
      3'd3: per = P3;
      3'd4: per = P4;
      3'd5: per = P5;
      3'd6: per = P6;
      default: per = P7;
    endcase
  end

  // Speed changes are only picked up at a reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= per - ONE;
    end else if (reload_i || cnt_q == '0) begin
      cnt_q <= per - ONE;
    end else begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign beat_tick_o   = (cnt_q == '0);
  assign note_window_o = (cnt_q < per - GRD);

endmodule

// File: rtl/tempo_record_ctrl.sv
// Record/playback sequencer: key edge detect, record/play FSM and
// note RAM address/length tracking, stepped by the beat generator.
module tempo_record_ctrl
  import tempo_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned CNT_W  = 27,
  parameter int unsigned GUARD  = 10000,
  parameter int unsigned ADDR_W = 6,
  parameter bit          LOOP   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic              back,
  input  logic [1:0]        mode,
  input  logic [2:0]        speed,
  output logic              beat_tick,
  output logic              note_window,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic [2:0]        state
);

  localparam logic [ADDR_W-1:0] A_LAST  = '1;
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   L_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic              full_q;
  logic              sel_prev_q, sel_rel_q;
  logic              bk_prev_q, bk_prs_q;

  logic tick, enter_rec, enter_play, play_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_prev_q <= 1'b0;
      sel_rel_q  <= 1'b0;
      bk_prev_q  <= 1'b0;
      bk_prs_q   <= 1'b0;
    end else begin
      sel_prev_q <= select;
      sel_rel_q  <= sel_prev_q & ~select;
      bk_prev_q  <= back;
      bk_prs_q   <= back & ~bk_prev_q;
    end
  end

  assign enter_rec  = (state_q == S_ARMED) && sel_rel_q && !bk_prs_q;
  assign enter_play = (state_q == S_IDLE) && sel_rel_q &&
                      (mode == MODE_PLAY) && (len_q != '0);
  assign play_last  = ({1'b0, addr_q} == len_q - L_ONE);

  tempo_record_ctrl_beat_gen #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W),
    .GUARD  (GUARD)
  ) u_beat_gen (
    .clk           (clk),
    .reset         (reset),
    .speed_i       (speed),
    .reload_i      (enter_rec | enter_play),
    .beat_tick_o   (tick),
    .note_window_o (note_window)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_rel_q && mode == MODE_REC) begin
            state_q <= S_ARMED;
          end else if (enter_play) begin
            state_q <= S_PLAY;
            addr_q  <= '0;
          end
        end
        S_ARMED: begin
          if (bk_prs_q) begin
            state_q <= S_IDLE;
          end else if (sel_rel_q) begin
            state_q <= S_REC;
            addr_q  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
          end
        end
        S_REC: begin
          // A stop release on a beat still keeps that beat's note.
          if (tick) begin
            if (addr_q == A_LAST) begin
              len_q   <= LEN_MAX;
              full_q  <= 1'b1;
              state_q <= S_STOP;
            end else begin
              addr_q <= addr_q + A_ONE;
              len_q  <= len_q + L_ONE;
            end
          end
          if (sel_rel_q) state_q <= S_STOP;
        end
        S_STOP: begin
          if (sel_rel_q || bk_prs_q) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
          end
        end
        S_PLAY: begin
          if (bk_prs_q) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
          end else if (tick) begin
            if (play_last) begin
              addr_q <= '0;
              if (!LOOP) state_q <= S_IDLE;
            end else begin
              addr_q <= addr_q + A_ONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign beat_tick = tick;
  assign wr_en     = (state_q == S_REC) && tick;
  assign rd_en     = (state_q == S_PLAY) && tick && !bk_prs_q;
  assign addr      = addr_q;
  assign rec_len   = len_q;
  assign full      = full_q;
  assign state     = state_q;

endmodule

// File: tb/tb_tempo_record_ctrl.sv
// Bench for tempo_record_ctrl: two instances (looping and one-shot playback)
// driven in lockstep, checked against beat arithmetic and note bookkeeping.
module tb_tempo_record_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       select = 1'b0;
  logic       back = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] speed = 3'd1;

  logic       tick1, win1, wr1, rd1, full1;
  logic [2:0] addr1, st1;
  logic [3:0] len1;
  logic       tick0, win0, wr0, rd0, full0;
  logic [2:0] addr0, st0;
  logic [3:0] len0;

  int n_asrt = 0;
  int n_fail = 0;

  int bpm_tab [8] = '{40, 60, 80, 100, 120, 140, 180, 220};

  always #5 clk = ~clk;

  tempo_record_ctrl #(
    .CLK_HZ(1000), .CNT_W(27), .GUARD(2), .ADDR_W(3), .LOOP(1'b1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .select(select), .back(back),
    .mode(mode), .speed(speed), .beat_tick(tick1), .note_window(win1),
    .wr_en(wr1), .rd_en(rd1), .addr(addr1), .rec_len(len1),
    .full(full1), .state(st1)
  );

  tempo_record_ctrl #(
    .CLK_HZ(1000), .CNT_W(27), .GUARD(2), .ADDR_W(3), .LOOP(1'b0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .select(select), .back(back),
    .mode(mode), .speed(speed), .beat_tick(tick0), .note_window(win0),
    .wr_en(wr0), .rd_en(rd0), .addr(addr0), .rec_len(len0),
    .full(full0), .state(st0)
  );

  function automatic int per(input int idx);
    return 60000 / bpm_tab[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rel_sel();
    select = 1'b1;
    step();
    select = 1'b0;
    step();
    step();
  endtask

  task automatic prs_bk();
    back = 1'b1;
    step();
    back = 1'b0;
    step();
  endtask

  task automatic next_beat(output int gap);
    gap = 0;
    do begin
      step();
      gap++;
    end while (tick1 !== 1'b1 && gap < 4000);
    chk("beat_seen", tick1, 1);
  endtask

  initial begin
    int g, r, old_s, new_s, spd, n, m, k;

    // reset state
    step();
    chk("rst_state", st1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_len", len1, 0);
    chk("rst_full", full1, 0);
    chk("rst_wr", wr1, 0);
    chk("rst_rd", rd1, 0);
    chk("rst_tick", tick1, 0);
    reset = 1'b0;

    // beat spacing and note window
    next_beat(g);
    step();
    chk("win_t1", win1, 0);
    step();
    chk("win_t2", win1, 0);
    step();
    chk("win_t3", win1, 1);
    next_beat(g);
    chk("gap_60", g + 3, per(1));
    r = $urandom_range(10, 900);
    steps(r);
    speed = 3'd0;
    next_beat(g);
    chk("gap_old", r + g, per(1));
    next_beat(g);
    chk("gap_new", g, per(0));
    old_s = 0;
    for (int i = 0; i < 2; i++) begin
      new_s = $urandom_range(0, 7);
      r = $urandom_range(1, per(old_s) - 2);
      steps(r);
      speed = 3'(new_s);
      next_beat(g);
      chk("rgap_old", r + g, per(old_s));
      next_beat(g);
      chk("rgap_new", g, per(new_s));
      old_s = new_s;
    end

    // record n notes then stop
    spd = $urandom_range(3, 7);
    speed = 3'(spd);
    mode = 2'd1;
    rel_sel();
    chk("armed", st1, 1);
    rel_sel();
    chk("rec", st1, 2);
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      next_beat(g);
      if (i == 0) chk("first_gap", g + 1, per(spd));
      else chk("rec_gap", g, per(spd));
      chk("rec_wr", wr1, 1);
      chk("rec_addr", addr1, i);
    end
    rel_sel();
    chk("stop", st1, 3);
    chk("stop_len", len1, n);
    chk("stop_full", full1, 0);

    // playback: looping vs one-shot
    rel_sel();
    chk("stop_idle", st1, 0);
    chk("stop_addr", addr1, 0);
    mode = 2'd2;
    rel_sel();
    chk("play", st1, 4);
    chk("play0", st0, 4);
    m = n + $urandom_range(1, n);
    for (int j = 0; j < m; j++) begin
      next_beat(g);
      chk("play_rd", rd1, 1);
      chk("play_addr", addr1, j % n);
      if (j < n) begin
        chk("once_rd", rd0, 1);
        chk("once_addr", addr0, j);
      end else begin
        chk("once_quiet", rd0, 0);
      end
    end
    chk("once_idle", st0, 0);
    prs_bk();
    chk("back_idle", st1, 0);
    chk("back_addr", addr1, 0);

    // record until the RAM fills
    mode = 2'd1;
    rel_sel();
    rel_sel();
    chk("rec2", st1, 2);
    for (int j = 0; j < 8; j++) begin
      next_beat(g);
      chk("fill_wr", wr1, 1);
      chk("fill_addr", addr1, j);
    end
    step();
    chk("fill_stop", st1, 3);
    chk("fill_len", len1, 8);
    chk("fill_full", full1, 1);
    next_beat(g);
    chk("no_9th", wr1, 0);

    // stop release landing on a beat
    rel_sel();
    rel_sel();
    rel_sel();
    chk("rec3", st1, 2);
    chk("rec3_full", full1, 0);
    k = $urandom_range(1, 3);
    for (int j = 0; j < k; j++) begin
      next_beat(g);
      chk("co_wr", wr1, 1);
    end
    steps(per(spd) - 2);
    select = 1'b1;
    step();
    select = 1'b0;
    step();
    chk("co_tick", tick1, 1);
    chk("co_wr_last", wr1, 1);
    chk("co_addr", addr1, k);
    step();
    chk("co_stop", st1, 3);
    chk("co_len", len1, k + 1);

    // async reset in the middle of a recording
    rel_sel();
    rel_sel();
    rel_sel();
    for (int j = 0; j < 4; j++) next_beat(g);
    step();
    step();
    chk("pre_addr", addr1, 4);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_state", st1, 0);
    chk("ar_addr", addr1, 0);
    chk("ar_len", len1, 0);
    chk("ar_full", full1, 0);
    chk("ar_wr", wr1, 0);
    chk("ar_tick", tick1, 0);
    #1;
    reset = 1'b0;
    step();
    mode = 2'd2;
    rel_sel();
    step();
    chk("no_play", st1, 0);
    chk("no_play_rd", rd1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
